// File: rtl/pc_trap_unit_pkg.sv
// -----------------------------------------------------------------------------
// pc_trap_unit_pkg
// Shared definitions for the PC / trap datapath:
//   - PCSrc select codes (shared with control_unit)
//   - Cause register codes
//   - trap sequencing state type
// -----------------------------------------------------------------------------
package pc_trap_unit_pkg;

   // PCSrc codes; 4..7 hold the current PC
   localparam logic [2:0] PCSRC_ALURESULT = 3'd0;
   localparam logic [2:0] PCSRC_ALUOUT    = 3'd1;
   localparam logic [2:0] PCSRC_REGA      = 3'd2;
   localparam logic [2:0] PCSRC_JUMP      = 3'd3;

   // Cause codes
   localparam logic [1:0] CAUSE_EXC0 = 2'd0;
   localparam logic [1:0] CAUSE_EXC1 = 2'd1;
   localparam logic [1:0] CAUSE_SYS  = 2'd2;
   localparam logic [1:0] CAUSE_IRQ  = 2'd3;

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_HANDLER = 2'b01,
      ST_RETURN  = 2'b10
   } state_t;

endpackage

// File: rtl/pc_trap_unit_next_pc_mux.sv
// -----------------------------------------------------------------------------
// next_pc_mux
// Combinational next-PC selection: branch-take decision, jump-target
// formation and the PCSrc multiplexer. No adder; PC+2 arrives via ALUResult.
// Ports:
//   i_pc          current program counter
//   i_alu_result  live ALU output (PC+2 in Fetch)
//   i_alu_out     registered ALU output (branch target)
//   i_rega        register operand (jr)
//   i_jump_imm    IR[11:0]
//   i_pcsrc       target select
//   i_pcwrite     unconditional PC write
//   i_is_branch   conditional branch cycle
//   i_is_bieq     1 = BEQ, 0 = BNE
//   i_zero        ALU zero flag
//   o_pc_next     PC value for the next cycle (i_pc when no write)
// -----------------------------------------------------------------------------
module next_pc_mux
   import pc_trap_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] i_pc,
   input  logic [WIDTH-1:0] i_alu_result,
   input  logic [WIDTH-1:0] i_alu_out,
   input  logic [WIDTH-1:0] i_rega,
   input  logic [11:0]      i_jump_imm,
   input  logic [2:0]       i_pcsrc,
   input  logic             i_pcwrite,
   input  logic             i_is_branch,
   input  logic             i_is_bieq,
   input  logic             i_zero,
   output logic [WIDTH-1:0] o_pc_next
);

   logic             w_take;
   logic             w_pc_wr;
   logic [WIDTH-1:0] w_jump;
   logic [WIDTH-1:0] w_target;

   // Taken when Zero matches the branch sense (BEQ wants 1, BNE wants 0)
   assign w_take  = i_is_branch & ~(i_zero ^ i_is_bieq);
   assign w_pc_wr = i_pcwrite | w_take;

   // Jump keeps the top PC bits as the region, word-aligned immediate below
   assign w_jump  = {i_pc[WIDTH-1:13], i_jump_imm, 1'b0};

   always_comb begin
      w_target = i_pc;
      case (i_pcsrc)
         PCSRC_ALURESULT: w_target = i_alu_result;
         PCSRC_ALUOUT:    w_target = i_alu_out;
         PCSRC_REGA:      w_target = i_rega;
         PCSRC_JUMP:      w_target = w_jump;
         default:         w_target = i_pc;
      endcase
   end

   assign o_pc_next = w_pc_wr ? w_target : i_pc;

endmodule

// File: rtl/pc_trap_unit.sv
// -----------------------------------------------------------------------------
// pc_trap_unit
// Owns PC, EPC and Cause. Sequences traps (syscall / exception / external
// IRQ) at instruction boundaries into the handler at TRAP_VEC, and the return
// from handler back to EPC.
// Ports:
//   CLK, Reset_n        clock, asynchronous active-low reset
//   PCWrite, isBranch,
//   isBIEQ, Zero, PCSrc next-PC controls from control_unit / ALU
//   ALUResult, ALUOut,
//   RegA, JumpImm       next-PC candidate sources
//   syscall, EPCWrite,
//   IntCause            trap request pulses and exception cause bit
//   EretReq             return-from-handler pulse
//   AtBoundary          last cycle of an instruction
//   IrqIn               external interrupt request (level)
//   IrqAck              one-cycle acknowledge when the IRQ is taken
//   PC, EPC, Cause      architectural registers
//   InHandler           handler active (IRQs masked)
//   Fault               sticky: trap in handler or EretReq outside handler
// -----------------------------------------------------------------------------
module pc_trap_unit
   import pc_trap_unit_pkg::*;
#(
   parameter int unsigned      WIDTH     = 16,
   parameter logic [WIDTH-1:0] RESET_VEC = 16'h0000,
   parameter logic [WIDTH-1:0] TRAP_VEC  = 16'h0010,
   parameter int unsigned      CAUSE_W   = 2
) (
   input  logic               CLK,
   input  logic               Reset_n,
   input  logic               PCWrite,
   input  logic               isBranch,
   input  logic               isBIEQ,
   input  logic               Zero,
   input  logic [2:0]         PCSrc,
   input  logic [WIDTH-1:0]   ALUResult,
   input  logic [WIDTH-1:0]   ALUOut,
   input  logic [WIDTH-1:0]   RegA,
   input  logic [11:0]        JumpImm,
   input  logic               syscall,
   input  logic               EPCWrite,
   input  logic               IntCause,
   input  logic               EretReq,
   input  logic               AtBoundary,
   input  logic               IrqIn,
   output logic               IrqAck,
   output logic [WIDTH-1:0]   PC,
   output logic [WIDTH-1:0]   EPC,
   output logic [CAUSE_W-1:0] Cause,
   output logic               InHandler,
   output logic               Fault
);

   state_t               r_state;
   logic [WIDTH-1:0]     r_pc;
   logic [WIDTH-1:0]     r_epc;
   logic [CAUSE_W-1:0]   r_cause;
   logic                 r_irq_ack;
   logic                 r_in_handler;
   logic                 r_fault;
   logic                 r_trap_pend;
   logic [1:0]           r_tcause;
   logic                 r_irq_pend;

   logic [WIDTH-1:0]     w_pc_next;
   logic                 w_trap_now;
   logic [1:0]           w_tcause_now;
   logic                 w_trap_any;
   logic [1:0]           w_tcause_any;
   logic                 w_enter;

   next_pc_mux #(
      .WIDTH (WIDTH)
   ) u_next_pc_mux (
      .i_pc         (r_pc),
      .i_alu_result (ALUResult),
      .i_alu_out    (ALUOut),
      .i_rega       (RegA),
      .i_jump_imm   (JumpImm),
      .i_pcsrc      (PCSrc),
      .i_pcwrite    (PCWrite),
      .i_is_branch  (isBranch),
      .i_is_bieq    (isBIEQ),
      .i_zero       (Zero),
      .o_pc_next    (w_pc_next)
   );

   assign w_trap_now   = syscall | EPCWrite;
   assign w_tcause_now = syscall ? CAUSE_SYS : (IntCause ? CAUSE_EXC1 : CAUSE_EXC0);

   // A trap pulse arriving on the boundary cycle itself is folded in here so
   // it is taken at that boundary rather than one instruction later.
   assign w_trap_any   = r_trap_pend | w_trap_now;
   assign w_tcause_any = w_trap_now ? w_tcause_now : r_tcause;
   assign w_enter      = (r_state == ST_RUN) & AtBoundary & (w_trap_any | r_irq_pend);

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state      <= ST_RUN;
         r_pc         <= RESET_VEC;
         r_epc        <= '0;
         r_cause      <= '0;
         r_irq_ack    <= 1'b0;
         r_in_handler <= 1'b0;
         r_fault      <= 1'b0;
         r_trap_pend  <= 1'b0;
         r_tcause     <= '0;
         r_irq_pend   <= 1'b0;
      end else begin
         r_irq_ack <= 1'b0;
         case (r_state)
            ST_RUN: begin
               if (EretReq)
                  r_fault <= 1'b1;
               if (w_enter) begin
                  r_epc        <= w_pc_next;
                  r_pc         <= TRAP_VEC;
                  r_state      <= ST_HANDLER;
                  r_in_handler <= 1'b1;
                  if (w_trap_any) begin
                     // Trap wins; any IRQ stays pending for after the return
                     r_cause     <= CAUSE_W'(w_tcause_any);
                     r_trap_pend <= 1'b0;
                     r_irq_pend  <= r_irq_pend | IrqIn;
                  end else begin
                     r_cause    <= CAUSE_W'(CAUSE_IRQ);
                     r_irq_ack  <= 1'b1;
                     r_irq_pend <= 1'b0;
                  end
               end else begin
                  r_pc <= w_pc_next;
                  if (w_trap_now) begin
                     r_trap_pend <= 1'b1;
                     r_tcause    <= w_tcause_now;
                  end
                  if (IrqIn)
                     r_irq_pend <= 1'b1;
               end
            end
            ST_HANDLER: begin
               r_pc <= w_pc_next;
               if (w_trap_now)
                  r_fault <= 1'b1;
               if (EretReq)
                  r_state <= ST_RETURN;
            end
            ST_RETURN: begin
               if (w_trap_now)
                  r_fault <= 1'b1;
               if (AtBoundary) begin
                  r_pc         <= r_epc;
                  r_state      <= ST_RUN;
                  r_in_handler <= 1'b0;
               end else begin
                  r_pc <= w_pc_next;
               end
            end
            default: begin
               r_state      <= ST_RUN;
               r_in_handler <= 1'b0;
            end
         endcase
      end
   end

   assign PC        = r_pc;
   assign EPC       = r_epc;
   assign Cause     = r_cause;
   assign IrqAck    = r_irq_ack;
   assign InHandler = r_in_handler;
   assign Fault     = r_fault;

endmodule

// File: tb/tb_pc_trap_unit.sv
module tb_pc_trap_unit;

   logic        CLK = 1'b0;
   logic        Reset_n;
   logic        PCWrite, isBranch, isBIEQ, Zero;
   logic [2:0]  PCSrc;
   logic [15:0] ALUResult, ALUOut, RegA;
   logic [11:0] JumpImm;
   logic        syscall, EPCWrite, IntCause, EretReq, AtBoundary, IrqIn;
   logic        IrqAck;
   logic [15:0] PC, EPC;
   logic [1:0]  Cause;
   logic        InHandler, Fault;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state
   logic [15:0] m_pc, m_epc;
   logic [1:0]  m_cause, m_tcause;
   bit          m_inh, m_ret, m_fault, m_ack, m_trap_pend, m_irq_pend;

   always #5 CLK = ~CLK;

   pc_trap_unit #(
      .WIDTH     (16),
      .RESET_VEC (16'h0000),
      .TRAP_VEC  (16'h0010),
      .CAUSE_W   (2)
   ) dut (
      .CLK        (CLK),
      .Reset_n    (Reset_n),
      .PCWrite    (PCWrite),
      .isBranch   (isBranch),
      .isBIEQ     (isBIEQ),
      .Zero       (Zero),
      .PCSrc      (PCSrc),
      .ALUResult  (ALUResult),
      .ALUOut     (ALUOut),
      .RegA       (RegA),
      .JumpImm    (JumpImm),
      .syscall    (syscall),
      .EPCWrite   (EPCWrite),
      .IntCause   (IntCause),
      .EretReq    (EretReq),
      .AtBoundary (AtBoundary),
      .IrqIn      (IrqIn),
      .IrqAck     (IrqAck),
      .PC         (PC),
      .EPC        (EPC),
      .Cause      (Cause),
      .InHandler  (InHandler),
      .Fault      (Fault)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 16'h0000; m_epc = 16'h0000; m_cause = 2'd0; m_tcause = 2'd0;
      m_inh = 0; m_ret = 0; m_fault = 0; m_ack = 0; m_trap_pend = 0; m_irq_pend = 0;
   endtask

   // One clock of architectural behaviour, derived from the rules directly
   task automatic model_step();
      logic [15:0] tgt, nxt;
      bit          take, trap_now, have_trap;
      logic [1:0]  tc_now, tc;
      case (PCSrc)
         3'd0:    tgt = ALUResult;
         3'd1:    tgt = ALUOut;
         3'd2:    tgt = RegA;
         3'd3:    tgt = (m_pc & 16'hE000) | ({4'h0, JumpImm} << 1);
         default: tgt = m_pc;
      endcase
      take     = isBranch && (isBIEQ ? Zero : !Zero);
      nxt      = (PCWrite || take) ? tgt : m_pc;
      trap_now = syscall || EPCWrite;
      tc_now   = syscall ? 2'd2 : {1'b0, IntCause};
      m_ack    = 0;
      if (!m_inh) begin
         have_trap = m_trap_pend || trap_now;
         tc        = trap_now ? tc_now : m_tcause;
         if (EretReq) m_fault = 1;
         if (AtBoundary && (have_trap || m_irq_pend)) begin
            m_epc = nxt; m_pc = 16'h0010; m_inh = 1; m_ret = 0;
            if (have_trap) begin
               m_cause = tc; m_trap_pend = 0; m_irq_pend = m_irq_pend || IrqIn;
            end else begin
               m_cause = 2'd3; m_ack = 1; m_irq_pend = 0;
            end
         end else begin
            m_pc = nxt;
            if (trap_now) begin m_trap_pend = 1; m_tcause = tc_now; end
            if (IrqIn) m_irq_pend = 1;
         end
      end else begin
         if (trap_now) m_fault = 1;
         if (m_ret && AtBoundary) begin
            m_pc = m_epc; m_inh = 0; m_ret = 0;
         end else begin
            m_pc = nxt;
            if (EretReq) m_ret = 1;
         end
      end
   endtask

   task automatic check_all(input string where);
      chk({where, ".PC"},        PC,                  m_pc);
      chk({where, ".EPC"},       EPC,                 m_epc);
      chk({where, ".Cause"},     {14'h0, Cause},      {14'h0, m_cause});
      chk({where, ".InHandler"}, {15'h0, InHandler},  {15'h0, m_inh});
      chk({where, ".Fault"},     {15'h0, Fault},      {15'h0, m_fault});
      chk({where, ".IrqAck"},    {15'h0, IrqAck},     {15'h0, m_ack});
   endtask

   task automatic idle();
      PCWrite = 0; isBranch = 0; isBIEQ = 0; Zero = 0; PCSrc = 3'd4;
      syscall = 0; EPCWrite = 0; IntCause = 0; EretReq = 0; AtBoundary = 0; IrqIn = 0;
   endtask

   task automatic cycle(input string where);
      @(posedge CLK);
      model_step();
      #1;
      check_all(where);
   endtask

   // Asynchronous reset asserted between edges, checked before any edge
   task automatic mid_reset(input string where);
      #2 Reset_n = 0;
      #1;
      model_reset();
      check_all(where);
      @(negedge CLK);
      Reset_n = 1;
   endtask

   initial begin
      Reset_n = 0;
      idle();
      ALUResult = '0; ALUOut = '0; RegA = '0; JumpImm = '0;
      model_reset();
      #3;
      check_all("reset");
      chk("reset.PC0", PC, 16'h0000);
      @(negedge CLK);
      Reset_n = 1;

      // Straight PC write
      PCWrite = 1; PCSrc = 3'd0; ALUResult = 16'h0102;
      cycle("wr");
      chk("wr.PC", PC, 16'h0102);

      // BNE taken, then not taken
      idle(); isBranch = 1; isBIEQ = 0; Zero = 0; PCSrc = 3'd1; ALUOut = 16'h0200;
      cycle("bne_t");
      chk("bne_t.PC", PC, 16'h0200);
      Zero = 1; ALUOut = 16'h0300;
      cycle("bne_nt");
      chk("bne_nt.PC", PC, 16'h0200);

      // Jump
      idle(); PCWrite = 1; PCSrc = 3'd2; RegA = 16'h1234;
      cycle("jr");
      PCSrc = 3'd3; JumpImm = 12'h0AB;
      cycle("jump");
      chk("jump.PC", PC, 16'h0156);

      // Syscall on the boundary cycle, then return
      idle(); PCWrite = 1; PCSrc = 3'd0; ALUResult = 16'h0042; syscall = 1; AtBoundary = 1;
      cycle("sys");
      chk("sys.EPC", EPC, 16'h0042);
      chk("sys.Cause", {14'h0, Cause}, 16'd2);
      chk("sys.PC", PC, 16'h0010);
      idle(); EretReq = 1;
      cycle("eret");
      idle(); AtBoundary = 1;
      cycle("ret");
      chk("ret.PC", PC, 16'h0042);
      chk("ret.InH", {15'h0, InHandler}, 16'd0);

      // One-cycle IRQ pulse taken at a later boundary
      idle(); IrqIn = 1;
      cycle("irq_in");
      idle();
      cycle("irq_wait");
      PCWrite = 1; PCSrc = 3'd0; ALUResult = 16'h0050; AtBoundary = 1;
      cycle("irq_take");
      chk("irq_take.Ack", {15'h0, IrqAck}, 16'd1);
      chk("irq_take.Cause", {14'h0, Cause}, 16'd3);
      chk("irq_take.EPC", EPC, 16'h0050);
      idle();
      cycle("irq_ack_drop");
      chk("irq_ack_drop.Ack", {15'h0, IrqAck}, 16'd0);
      EretReq = 1; cycle("irq_eret");
      idle(); AtBoundary = 1; cycle("irq_ret");
      chk("irq_ret.PC", PC, 16'h0050);

      // Exception and IRQ both pending: trap first, IRQ after the return
      idle(); EPCWrite = 1; IntCause = 1; IrqIn = 1;
      cycle("both_in");
      idle(); PCWrite = 1; PCSrc = 3'd0; ALUResult = 16'h0060; AtBoundary = 1;
      cycle("both_trap");
      chk("both_trap.Cause", {14'h0, Cause}, 16'd1);
      chk("both_trap.Ack", {15'h0, IrqAck}, 16'd0);
      idle(); EretReq = 1; cycle("both_eret");
      idle(); AtBoundary = 1; cycle("both_ret");
      chk("both_ret.PC", PC, 16'h0060);
      chk("both_ret.InH", {15'h0, InHandler}, 16'd0);
      PCWrite = 1; PCSrc = 3'd0; ALUResult = 16'h0070;
      cycle("both_irq");
      chk("both_irq.Ack", {15'h0, IrqAck}, 16'd1);
      chk("both_irq.Cause", {14'h0, Cause}, 16'd3);
      idle(); EretReq = 1; cycle("both_eret2");
      idle(); AtBoundary = 1; cycle("both_ret2");

      // Syscall inside handler faults without touching EPC
      idle(); PCWrite = 1; PCSrc = 3'd0; ALUResult = 16'h0080; syscall = 1; AtBoundary = 1;
      cycle("h_enter");
      idle(); syscall = 1;
      cycle("h_sys");
      chk("h_sys.Fault", {15'h0, Fault}, 16'd1);
      chk("h_sys.EPC", EPC, 16'h0080);

      // Reset while in handler
      idle();
      mid_reset("h_reset");
      chk("h_reset.InH", {15'h0, InHandler}, 16'd0);

      // EretReq while running
      EretReq = 1;
      cycle("run_eret");
      chk("run_eret.Fault", {15'h0, Fault}, 16'd1);
      chk("run_eret.PC", PC, 16'h0000);

      // Randomised traffic against the model
      for (int i = 0; i < 600; i++) begin
         PCWrite    = 1'($urandom_range(0, 1));
         isBranch   = 1'($urandom_range(0, 1));
         isBIEQ     = 1'($urandom_range(0, 1));
         Zero       = 1'($urandom_range(0, 1));
         PCSrc      = 3'($urandom_range(0, 7));
         ALUResult  = 16'($urandom);
         ALUOut     = 16'($urandom);
         RegA       = 16'($urandom);
         JumpImm    = 12'($urandom);
         syscall    = ($urandom_range(0, 19) == 0);
         EPCWrite   = ($urandom_range(0, 19) == 0);
         IntCause   = 1'($urandom_range(0, 1));
         EretReq    = ($urandom_range(0, 14) == 0);
         AtBoundary = ($urandom_range(0, 2) == 0);
         IrqIn      = ($urandom_range(0, 9) == 0);
         cycle("rand");
         if (i % 150 == 149) begin
            idle();
            mid_reset("rand_reset");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
